// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding.
`timescale 1ns/1ps
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Trigger/level bundle between a pulse source and the pulse stretcher.
`timescale 1ns/1ps
interface pulse_stretcher_if #(
  parameter int CNT_W = 8
);
  logic             in_pulse;
  logic [CNT_W-1:0] len;
  logic             out_sig;
  logic             busy;
  logic             drop;

  modport master (output in_pulse, len, input out_sig, busy, drop);
  modport slave  (input in_pulse, len, output out_sig, busy, drop);
endinterface

// File: rtl/pulse_down_counter.sv
// Loadable down counter that saturates at zero; load has priority over dec.
`timescale 1ns/1ps
module pulse_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Widens single-cycle triggers into an out_sig level of len cycles, then holds a low gap.
`timescale 1ns/1ps
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int GAP_CYC   = 2,
  parameter int RETRIGGER = 0
) (
  input  logic              clk,
  input  logic              rstn,
  pulse_stretcher_if.slave  bus
);

  localparam int GCNT_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [GCNT_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GCNT_W'(GAP_CYC - 1) : '0;

  state_e state_q, state_d;
  logic   out_sig_q, out_sig_d;
  logic   busy_q, busy_d;
  logic   drop_q, drop_d;
  logic   h_load, h_dec, h_zero;
  logic   g_load, g_dec, g_zero;
  logic [CNT_W-1:0] len_eff;

  // A zero length still produces a one-cycle pulse.
  assign len_eff = (bus.len == '0) ? CNT_W'(1) : bus.len;

  pulse_down_counter #(.W(CNT_W)) u_hcnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (h_load),
    .load_val (len_eff - CNT_W'(1)),
    .dec      (h_dec),
    .zero     (h_zero)
  );

  pulse_down_counter #(.W(GCNT_W)) u_gcnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (g_load),
    .load_val (GAP_LOAD),
    .dec      (g_dec),
    .zero     (g_zero)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    out_sig_d = out_sig_q;
    busy_d    = busy_q;
    drop_d    = 1'b0;
    h_load    = 1'b0;
    h_dec     = 1'b0;
    g_load    = 1'b0;
    g_dec     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_pulse) begin
          out_sig_d = 1'b1;
          busy_d    = 1'b1;
          h_load    = 1'b1;
          state_d   = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (bus.in_pulse && RETRIGGER != 0) begin
          h_load = 1'b1;
        end else begin
          drop_d = bus.in_pulse;
          if (!h_zero) begin
            h_dec = 1'b1;
          end else begin
            out_sig_d = 1'b0;
            if (GAP_CYC > 0) begin
              g_load  = 1'b1;
              state_d = ST_GAP;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_GAP: begin
        drop_d = bus.in_pulse;
        if (!g_zero) begin
          g_dec = 1'b1;
        end else begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        out_sig_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // NOTE: only control/state flops exist here and all take the async reset; nothing is memory-like.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      out_sig_q <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_sig_q <= out_sig_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.out_sig = out_sig_q;
  assign bus.busy    = busy_q;
  assign bus.drop    = drop_q;

endmodule
